uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver (8N1, LSB first) that converts the raw `uart_rx` pin into bytes for the MARVIN core. It replaces the direct use of the pin inside `marvin` with a synchronised, oversampled, majority-voted receiver. Each byte is delivered through a one-entry valid/ready holding register. Framing and overrun conditions are reported as single-cycle pulses.

## Interface
- `CLK_HZ`, default 50_000_000, frequency of `clk` in Hz.
- `BAUD`, default 115_200, line bit rate.
- `DIV`, localparam = round(CLK_HZ / (16·BAUD)), clocks per oversample tick, minimum 2. The default value is 27.

- `clk`  in  1  system clock; one clock domain for the whole block.
- `rst_`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  raw serial pin, asynchronous to `clk`, idle high.
- `data`  out  8  received byte, stable while `valid` is high.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` on a cycle where `valid && ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low; the byte is discarded.
- `overrun`  out  1  one-cycle pulse: a byte completed while the holding register was full; the new byte is dropped.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Input path:** `rx` passes through a 2-flop synchroniser (both flops reset to 1), then a 1-flop edge register. A falling edge is detected when the registered value is 1 and the synchronised value is 0.
- **Tick generator:** counts 0..DIV-1 and emits `tick` when the count reaches DIV-1. It restarts at 0 on start-edge detection, so tick phase is aligned to the edge.
- **Sample counter:** `s` runs 0..15 per bit and advances on `tick`. Samples are taken at s = 7, 8, 9, and the bit value is the majority of the three. The bit decision is made at s = 9; the bit ends at s = 15.
- **State machine:**
  - **IDLE:** on falling edge, clear `s` and the tick counter, then go to START.
  - **START:** at s = 9, if the majority is 1 it is a false start: go to IDLE with no output. Otherwise continue; at s = 15 go to DATA with bit index 0.
  - **DATA:** at s = 9, shift the majority into the shift register, LSB first. At s = 15 of bit 7 go to STOP; otherwise increment the bit index.
  - **STOP:** at s = 9 go to IDLE. A majority of 1 means the byte is good and is delivered. A majority of 0 pulses `frame_err` and discards the byte.
- **Break handling:** because IDLE triggers only on an edge, a line held low (break) never retriggers reception. The line must return high first.
- **Holding register, on good-byte completion:**
  - If `valid` is 0, or `valid && ready` in the same cycle: load `data` and set `valid`.
  - Otherwise: pulse `overrun`, keep the old `data` and keep `valid`.
- **Holding register, consumption:** `valid && ready` with no completion in that cycle clears `valid`. `data` keeps its last value.
- **Reset** (asserted at any time, including mid-byte): state goes to IDLE and all counters clear. Outputs reset to `data` = 0, `valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0. Any partial byte is lost.

## Timing
- Pin edge to edge detect: 3 clk.
- Edge detect to stop-bit decision: 153 ticks = 153·DIV clk.
- `valid`, `frame_err` and `overrun` assert 1 clk after the stop decision. Total pin-edge-to-`valid` latency is 153·DIV + 4 clk, with ±1 clk of synchroniser uncertainty.
- A byte completion and a consumer handshake in the same cycle are both honoured, with no bubble.
- The next start edge is accepted from the cycle after the stop decision, so back-to-back frames at full rate are received.
- Baud tolerance: the centre samples stay within the bit for a rate mismatch of ±4 %.

## Structure
- `pkg` gains `uart_rx_state_t`, an enum of IDLE, START, DATA and STOP.
- One sub-module, `uart_baud_tick`, holds the divider counter, the restart input and the `tick` output. All other logic stays in `uart_rx`.
- `marvin` instantiates `uart_rx` on its `uart_rx` port.

## Test plan
All scenarios use CLK_HZ = 1_600_000 and BAUD = 10_000, giving DIV = 10 and 160 clk per bit.
- **Basic byte:** send 0xA5 with `ready` = 1 → `valid` high for 1 cycle, `data` = 0xA5, rising 1534 ±1 clk after the pin edge; no error pulses.
- **Overrun:** hold `ready` = 0 and send 0x3C then 0x81 → `data` = 0x3C held; one `overrun` pulse on the second byte. Raising `ready` → one handshake with 0x3C, then `valid` = 0.
- **Framing error and break:** send 0x55 with the stop bit low, then hold low for 3 bit times → one `frame_err` pulse, `valid` stays 0, no re-trigger. Release high, then send 0x0F → 0x0F received correctly.
- **Glitch rejection:** pulse low for 40 clk → `busy` high until the START decision, then low; no `valid`, no `frame_err`.
- **Reset mid-byte:** assert `rst_` low in DATA bit 4 → all outputs 0 immediately. After release, send 0xC3 → 0xC3 received.
- **Rate tolerance:** send 0xFF, 0x00 and 0x96 back-to-back at bit periods of 154 and 166 clk → all three bytes received, no errors.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types, oversampling constants and helper functions for the UART receiver.
package uart_rx_pkg;

   // Receiver frame states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_rx_state_t;

   // Oversampling ratio: ticks per bit
   localparam int OVERSAMPLE = 16;

   // Sample-counter values, expressed as the value of s on the tick that
   // advances it. Samples land when s becomes 7, 8 and 9, and the bit
   // decision is taken on the tick that moves s to 9.
   localparam logic [3:0] S_SAMP_A  = 4'd6;
   localparam logic [3:0] S_SAMP_B  = 4'd7;
   localparam logic [3:0] S_DECIDE  = 4'd8;
   localparam logic [3:0] S_BIT_END = 4'd15;

   // Clocks per oversample tick, rounded to nearest, never below 2
   function automatic int calc_div(input int clk_hz, input int baud);
      int d;
      d = (clk_hz + ((OVERSAMPLE / 2) * baud)) / (OVERSAMPLE * baud);
      if (d < 2) begin
         d = 2;
      end
      return d;
   endfunction

   // Two-out-of-three majority vote
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: divides clk by DIV and can be re-phased to a
// start edge through i_restart.
module uart_baud_tick
   import uart_rx_pkg::*;
#(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic rst_,
   input  logic i_restart,
   output logic o_tick
);

   localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // Divider counter: wraps at DIV-1, forced to zero when a start edge is seen
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_cnt <= '0;
      end else if (i_restart) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, 16x oversampling with 3-sample
// majority vote, one-entry valid/ready holding register, and single-cycle
// frame-error / overrun pulses.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115_200
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);

   // Input path
   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic w_fall;

   // Timing
   logic w_tick;
   logic w_restart;
   logic w_decide;
   logic w_bit_end;

   // Frame FSM
   uart_rx_state_t r_state;
   uart_rx_state_t w_state_nxt;
   logic [3:0]     r_s;
   logic [3:0]     w_s_nxt;
   logic [2:0]     r_bit_idx;
   logic [2:0]     w_bit_idx_nxt;
   logic [7:0]     r_shift;
   logic [7:0]     w_shift_nxt;
   logic [1:0]     r_samp;
   logic [1:0]     w_samp_nxt;
   logic           w_bit_val;
   logic           w_good;
   logic           w_ferr;

   // Stop-decision results, one cycle before they reach the outputs
   logic r_good;
   logic r_ferr;

   // Output registers
   logic [7:0] r_data;
   logic       r_valid;
   logic       r_frame_err;
   logic       r_overrun;
   logic       r_busy;

   // Two-flop synchroniser plus edge register; idle-high reset avoids a
   // false edge when reset is released with the line idle
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_fall    = r_prev & ~r_sync2;
   assign w_restart = (r_state == ST_IDLE) && w_fall;

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clk       (clk),
      .rst_      (rst_),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   // The third sample is the live synchronised value on the decision tick
   assign w_bit_val = maj3(r_samp[0], r_samp[1], r_sync2);
   assign w_decide  = w_tick && (r_s == S_DECIDE);
   assign w_bit_end = w_tick && (r_s == S_BIT_END);

   // Frame FSM next-state: oversample bookkeeping, bit decisions, byte assembly
   always_comb begin
      w_state_nxt   = r_state;
      w_s_nxt       = r_s;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_samp_nxt    = r_samp;
      w_good        = 1'b0;
      w_ferr        = 1'b0;

      if ((r_state != ST_IDLE) && w_tick) begin
         w_s_nxt = r_s + 4'd1;
         if (r_s == S_SAMP_A) begin
            w_samp_nxt[0] = r_sync2;
         end else if (r_s == S_SAMP_B) begin
            w_samp_nxt[1] = r_sync2;
         end else begin
            w_samp_nxt = r_samp;
         end
      end else begin
         w_s_nxt = r_s;
      end

      case (r_state)
         ST_IDLE: begin
            // Only an edge starts a frame, so a held-low break never retriggers
            if (w_fall) begin
               w_state_nxt   = ST_START;
               w_s_nxt       = 4'd0;
               w_bit_idx_nxt = 3'd0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_START: begin
            if (w_decide && w_bit_val) begin
               // Line was back high at mid-bit: glitch, not a start bit
               w_state_nxt = ST_IDLE;
            end else if (w_bit_end) begin
               w_state_nxt   = ST_DATA;
               w_bit_idx_nxt = 3'd0;
            end else begin
               w_state_nxt = ST_START;
            end
         end
         ST_DATA: begin
            if (w_decide) begin
               // LSB arrives first, so shift in from the top
               w_shift_nxt = {w_bit_val, r_shift[7:1]};
            end else if (w_bit_end) begin
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = ST_STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed
            if (w_decide) begin
               w_state_nxt = ST_IDLE;
               if (w_bit_val) begin
                  w_good = 1'b1;
               end else begin
                  w_ferr = 1'b1;
               end
            end else begin
               w_state_nxt = ST_STOP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Frame FSM state and datapath registers
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state   <= ST_IDLE;
         r_s       <= 4'd0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
         r_samp    <= 2'b00;
         r_good    <= 1'b0;
         r_ferr    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_s       <= w_s_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_samp    <= w_samp_nxt;
         r_good    <= w_good;
         r_ferr    <= w_ferr;
         r_busy    <= (w_state_nxt != ST_IDLE);
      end
   end

   // Holding register: completion and consumption in the same cycle are both
   // honoured; a completion into a full, unconsumed register is an overrun
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_data      <= 8'd0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= r_ferr;
         r_overrun   <= 1'b0;
         if (r_good) begin
            if (!r_valid || ready) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && ready) begin
            r_valid <= 1'b0;
         end else begin
            r_valid <= r_valid;
         end
      end
   end

   assign data      = r_data;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = r_busy;

endmodule
